// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bundle: per-source result handshake plus the registered
// broadcast that every wakeup consumer (ROB, RS, LSB) listens to.
interface cdb_arbiter_if #(
  parameter int N_SRC     = 3,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
);

  logic [N_SRC-1:0]           req_valid;
  logic [N_SRC*ROB_IDX_W-1:0] req_rob_id;
  logic [N_SRC*DATA_W-1:0]    req_data;
  logic [N_SRC*ADDR_W-1:0]    req_target;
  logic [N_SRC-1:0]           req_ready;

  logic                       cdb_valid;
  logic [ROB_IDX_W-1:0]       cdb_rob_id;
  logic [DATA_W-1:0]          cdb_data;
  logic [ADDR_W-1:0]          cdb_target;
  logic [1:0]                 cdb_src;

  // Producer / consumer side: posts results, watches the broadcast.
  modport master (
    output req_valid, req_rob_id, req_data, req_target,
    input  req_ready,
    input  cdb_valid, cdb_rob_id, cdb_data, cdb_target, cdb_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_rob_id, req_data, req_target,
    output req_ready,
    output cdb_valid, cdb_rob_id, cdb_data, cdb_target, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each producer owns a one-entry holding buffer;
// a round-robin pick chooses one occupied buffer per cycle and drives it onto
// a registered broadcast. A buffer being drained may be refilled on the same
// edge, so a producer issuing every cycle only stalls when it loses arbitration.
// cdb_src is two bits wide, so at most four producers are supported.
module cdb_arbiter #(
  parameter int N_SRC     = 3,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  // Pointer starts on the last source so that source 0 has first priority.
  localparam logic [1:0] LAST_RST = 2'(N_SRC - 1);

  logic [N_SRC-1:0]     buf_v;
  logic [ROB_IDX_W-1:0] buf_rob [N_SRC];
  logic [DATA_W-1:0]    buf_data [N_SRC];
  logic [ADDR_W-1:0]    buf_tgt [N_SRC];

  logic [1:0]           last;

  logic [N_SRC-1:0]     grant;
  logic                 have_win;
  logic [1:0]           win;
  logic [ROB_IDX_W-1:0] win_rob;
  logic [DATA_W-1:0]    win_data;
  logic [ADDR_W-1:0]    win_tgt;

  logic                 live;
  logic [N_SRC-1:0]     take;

  logic                 cdb_valid_q;
  logic [ROB_IDX_W-1:0] cdb_rob_q;
  logic [DATA_W-1:0]    cdb_data_q;
  logic [ADDR_W-1:0]    cdb_tgt_q;
  logic [1:0]           cdb_src_q;

  // Nothing moves while frozen or while a flush is being applied.
  assign live = rdy & ~flush;

  // A slot is free if empty or if it is the one being broadcast this edge.
  assign bus.req_ready = {N_SRC{live}} & (~buf_v | grant);
  assign take          = bus.req_valid & bus.req_ready;

  // Round-robin scan starting just after the last winner; the inner loop
  // keeps every index constant so the wrap is a simple compare.
  always_comb begin
    grant    = '0;
    have_win = 1'b0;
    win      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!have_win && buf_v[i] &&
            ((int'(last) + k == i) || (int'(last) + k == i + N_SRC))) begin
          have_win = 1'b1;
          grant[i] = 1'b1;
          win      = 2'(i);
        end
      end
    end
  end

  // One-hot mux of the winning buffer onto the broadcast inputs.
  always_comb begin
    win_rob  = '0;
    win_data = '0;
    win_tgt  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        win_rob  = buf_rob[i];
        win_data = buf_data[i];
        win_tgt  = buf_tgt[i];
      end
    end
  end

  // Holding buffers: a fill wins over the drain of the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        buf_rob[i]  <= '0;
        buf_data[i] <= '0;
        buf_tgt[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        buf_v <= '0;
      end else begin
        for (int i = 0; i < N_SRC; i++) begin
          if (take[i]) begin
            buf_v[i]    <= 1'b1;
            buf_rob[i]  <= bus.req_rob_id[i*ROB_IDX_W +: ROB_IDX_W];
            buf_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
            buf_tgt[i]  <= bus.req_target[i*ADDR_W +: ADDR_W];
          end else if (grant[i]) begin
            buf_v[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered broadcast and round-robin pointer; payload holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_data_q  <= '0;
      cdb_tgt_q   <= '0;
      cdb_src_q   <= '0;
      last        <= LAST_RST;
    end else if (rdy) begin
      if (flush) begin
        cdb_valid_q <= 1'b0;
      end else if (have_win) begin
        cdb_valid_q <= 1'b1;
        cdb_rob_q   <= win_rob;
        cdb_data_q  <= win_data;
        cdb_tgt_q   <= win_tgt;
        cdb_src_q   <= win;
        last        <= win;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_q;
  assign bus.cdb_data   = cdb_data_q;
  assign bus.cdb_target = cdb_tgt_q;
  assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: expected broadcasts are queued as stimulus is issued
// and a monitor pops and compares them whenever a live edge produces cdb_valid.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic flush;

  int total = 0;
  int bad   = 0;

  cdb_arbiter_if #(.N_SRC(N), .ROB_IDX_W(RW), .DATA_W(DW), .ADDR_W(AW)) bus ();

  cdb_arbiter #(.N_SRC(N), .ROB_IDX_W(RW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    src;
    logic [RW-1:0] rob;
    logic [DW-1:0] data;
    logic [AW-1:0] tgt;
  } exp_t;

  typedef struct {
    logic [2:0] mask;
    int         n;
    logic [5:0] order;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_e(input int s, input int rob, input int data, input int tgt);
    exp_t e;
    e.src  = 2'(s);
    e.rob  = RW'(rob);
    e.data = DW'(data);
    e.tgt  = AW'(tgt);
    return e;
  endfunction

  function automatic exp_t mk_v(input int v, input int s);
    return mk_e(s, v*3 + s + 1, 32'h0C0D_0000 + v*256 + s, 32'h4000 + v*16 + s*4);
  endfunction

  task automatic drive(input exp_t e);
    bus.req_valid[e.src]                 = 1'b1;
    bus.req_rob_id[int'(e.src)*RW +: RW] = e.rob;
    bus.req_data[int'(e.src)*DW +: DW]   = e.data;
    bus.req_target[int'(e.src)*AW +: AW] = e.tgt;
  endtask

  task automatic clr();
    bus.req_valid = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d broadcasts still pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: only edges taken with rdy=1 out of reset produce news.
  initial begin
    bit   live;
    exp_t e;
    forever begin
      @(posedge clk);
      live = rdy && rst_n;
      @(negedge clk);
      if (live && bus.cdb_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bcast: got tag %0d src %0d, want no broadcast",
                   bus.cdb_rob_id, bus.cdb_src);
        end else begin
          e = sb.pop_front();
          check("bcast_src",  64'(bus.cdb_src),    64'(e.src));
          check("bcast_tag",  64'(bus.cdb_rob_id), 64'(e.rob));
          check("bcast_data", 64'(bus.cdb_data),   64'(e.data));
          check("bcast_tgt",  64'(bus.cdb_target), 64'(e.tgt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   alu_tag;
    bit   lsb_pend;
    int   stalls;
    int   cyc;
    exp_t e;

    // mask | broadcast order (src of 1st in bits 1:0); pointer carried by hand
    tbl[0] = '{mask: 3'b111, n: 3, order: {2'd2, 2'd1, 2'd0}};  // from reset
    tbl[1] = '{mask: 3'b001, n: 1, order: {2'd0, 2'd0, 2'd0}};  // last=2
    tbl[2] = '{mask: 3'b101, n: 2, order: {2'd0, 2'd0, 2'd2}};  // last=0
    tbl[3] = '{mask: 3'b110, n: 2, order: {2'd0, 2'd2, 2'd1}};  // last=0
    tbl[4] = '{mask: 3'b011, n: 2, order: {2'd0, 2'd1, 2'd0}};  // last=2
    tbl[5] = '{mask: 3'b100, n: 1, order: {2'd0, 2'd0, 2'd2}};  // last=1
    tbl[6] = '{mask: 3'b111, n: 3, order: {2'd2, 2'd1, 2'd0}};  // last=2
    tbl[7] = '{mask: 3'b010, n: 1, order: {2'd0, 2'd0, 2'd1}};  // last=2
    tbl[8] = '{mask: 3'b101, n: 2, order: {2'd0, 2'd0, 2'd2}};  // last=1
    tbl[9] = '{mask: 3'b111, n: 3, order: {2'd0, 2'd2, 2'd1}};  // last=0

    rst_n          = 1'b0;
    rdy            = 1'b1;
    flush          = 1'b0;
    bus.req_valid  = '0;
    bus.req_rob_id = '0;
    bus.req_data   = '0;
    bus.req_target = '0;
    #2;
    check("rst_valid",  64'(bus.cdb_valid),  64'd0);
    check("rst_tag",    64'(bus.cdb_rob_id), 64'd0);
    check("rst_data",   64'(bus.cdb_data),   64'd0);
    check("rst_tgt",    64'(bus.cdb_target), 64'd0);
    check("rst_src",    64'(bus.cdb_src),    64'd0);
    check("rst_ready",  64'(bus.req_ready),  64'b111);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table: simultaneous posts, fixed latency, back-to-back broadcasts.
    for (int v = 0; v < 10; v++) begin
      for (int s = 0; s < N; s++)
        if (tbl[v].mask[s]) drive(mk_v(v, s));
      for (int j = 0; j < tbl[v].n; j++)
        sb.push_back(mk_v(v, int'(tbl[v].order[j*2 +: 2])));
      step();
      clr();
      @(negedge clk);
      check($sformatf("v%0d_latency", v), 64'(bus.cdb_valid), 64'd0);
      for (int j = 0; j < tbl[v].n; j++) begin
        @(negedge clk);
        check($sformatf("v%0d_busy%0d", v, j), 64'(bus.cdb_valid), 64'd1);
      end
      @(negedge clk);
      check($sformatf("v%0d_idle", v), 64'(bus.cdb_valid), 64'd0);
      wait_drain($sformatf("v%0d_drain", v));
      step();
    end

    // Single ALU result: two cycles to broadcast, exactly one cycle wide.
    e = mk_e(0, 5, 32'h2A, 0);
    drive(e);
    sb.push_back(e);
    step();
    clr();
    @(negedge clk);
    check("single_lat", 64'(bus.cdb_valid), 64'd0);
    @(negedge clk);
    check("single_valid", 64'(bus.cdb_valid),  64'd1);
    check("single_tag",   64'(bus.cdb_rob_id), 64'd5);
    check("single_data",  64'(bus.cdb_data),   64'h2A);
    check("single_src",   64'(bus.cdb_src),    64'd0);
    @(negedge clk);
    check("single_once", 64'(bus.cdb_valid), 64'd0);
    wait_drain("single_drain");
    step();

    // Reset mid-operation discards loaded buffers and rewinds the pointer.
    drive(mk_e(0, 21, 1, 0));
    drive(mk_e(1, 22, 2, 0));
    drive(mk_e(2, 23, 3, 0));
    step();
    clr();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.cdb_valid), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'b111);
    step();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_quiet", 64'(bus.cdb_valid), 64'd0);
    step();

    // ALU streams tags 1..6 while LSB posts tag 9 once (pointer at 2).
    sb.push_back(mk_e(0, 1, 32'h101, 0));
    sb.push_back(mk_e(1, 9, 32'h900, 32'h80));
    for (int t = 2; t <= 6; t++) sb.push_back(mk_e(0, t, 32'h100 + t, 0));
    alu_tag  = 1;
    lsb_pend = 1'b1;
    stalls   = 0;
    cyc      = 0;
    while ((alu_tag <= 6 || lsb_pend) && cyc < 40) begin
      clr();
      if (alu_tag <= 6) drive(mk_e(0, alu_tag, 32'h100 + alu_tag, 0));
      if (lsb_pend) drive(mk_e(1, 9, 32'h900, 32'h80));
      @(negedge clk);
      if (alu_tag <= 6) begin
        if (bus.req_ready[0]) alu_tag++;
        else stalls++;
      end
      if (lsb_pend && bus.req_ready[1]) lsb_pend = 1'b0;
      step();
      cyc++;
    end
    clr();
    check("b2b_all_taken", 64'(alu_tag), 64'd7);
    check("b2b_stalls",    64'(stalls),  64'd1);
    wait_drain("b2b_drain");
    step();

    // Drain and refill of the ALU slot on the same edge (pointer at 0).
    e = mk_e(0, 11, 32'hB0B, 32'h20);
    drive(e);
    sb.push_back(e);
    step();
    e = mk_e(0, 12, 32'hB0C, 32'h24);
    drive(e);
    sb.push_back(e);
    @(negedge clk);
    check("refill_ready", 64'(bus.req_ready[0]), 64'd1);
    step();
    clr();
    @(negedge clk);
    check("refill_first",  64'(bus.cdb_rob_id), 64'd11);
    @(negedge clk);
    check("refill_second", 64'(bus.cdb_rob_id), 64'd12);
    check("refill_valid",  64'(bus.cdb_valid),  64'd1);
    @(negedge clk);
    check("refill_idle", 64'(bus.cdb_valid), 64'd0);
    wait_drain("refill_drain");
    step();

    // Flush while tags 4 and 7 sit in their buffers and tag 13 is on the bus.
    e = mk_e(2, 13, 32'hD, 0);
    drive(e);
    sb.push_back(e);
    step();
    clr();
    drive(mk_e(0, 4, 32'h44, 0));
    drive(mk_e(1, 7, 32'h77, 0));
    step();
    clr();
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready_low", 64'(bus.req_ready), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(bus.cdb_valid), 64'd0);
    check("flush_ready", 64'(bus.req_ready), 64'b111);
    repeat (5) @(negedge clk);
    wait_drain("flush_drain");
    step();

    // Freeze with tag 20 on the bus and tag 8 buffered; flush ignored meanwhile.
    e = mk_e(0, 20, 32'h2020, 32'h10);
    drive(e);
    sb.push_back(e);
    step();
    clr();
    e = mk_e(1, 8, 32'h808, 32'h30);
    drive(e);
    sb.push_back(e);
    step();
    clr();
    rdy = 1'b0;
    drive(mk_e(2, 30, 32'h3030, 0));
    for (int f = 0; f < 3; f++) begin
      step();
      flush = (f == 0);
      @(negedge clk);
      check($sformatf("freeze%0d_valid", f), 64'(bus.cdb_valid),  64'd1);
      check($sformatf("freeze%0d_tag", f),   64'(bus.cdb_rob_id), 64'd20);
      check($sformatf("freeze%0d_src", f),   64'(bus.cdb_src),    64'd0);
      check($sformatf("freeze%0d_ready", f), 64'(bus.req_ready),  64'd0);
    end
    clr();
    flush = 1'b0;
    rdy   = 1'b1;
    @(negedge clk);
    check("thaw_valid", 64'(bus.cdb_valid),  64'd1);
    check("thaw_tag",   64'(bus.cdb_rob_id), 64'd8);
    check("thaw_src",   64'(bus.cdb_src),    64'd1);
    @(negedge clk);
    check("thaw_once", 64'(bus.cdb_valid), 64'd0);
    wait_drain("thaw_drain");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
